// File: rtl/step_gear_pkg.sv
// step_gear shared types and defaults.
// FSM state encoding, default widths and a width helper.
package step_gear_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int DIV_BITS_DEF      = 20;
    localparam int DEBOUNCE_BITS_DEF = 16;
    localparam int CE_COUNT_W        = 32;

    // A zero-bit counter is still stored in one flop.
    function automatic int cnt_width(input int bits);
        return (bits > 0) ? bits : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button -> synchronized, debounced level -> one-cycle rise pulse.
// Release of the button produces no pulse.
module button_debounce
    import step_gear_pkg::*;
#(
    parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_BITS);
    localparam logic [CW-1:0] CNT_MAX =
        CW'((64'd1 << DEBOUNCE_BITS) - 64'd1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for 2^DEBOUNCE_BITS cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Registered pulse on each 0->1 transition of the debounced level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/step_gear.sv
// Run/halt/single-step clock-enable generator.
// Define STEP_BUTTON_INVERT_EN for buttons that read low when pressed.
module step_gear
    import step_gear_pkg::*;
#(
    parameter int DIV_BITS      = DIV_BITS_DEF,
    parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  run_btn,
    input  logic                  step_btn,
    output logic                  ce,
    output logic                  running,
    output logic [CE_COUNT_W-1:0] ce_count
);

    localparam int PW = cnt_width(DIV_BITS);
    localparam logic [PW-1:0] PRE_MAX =
        PW'((64'd1 << DIV_BITS) - 64'd1);

    logic          run_in;
    logic          step_in;
    logic          run_p;
    logic          step_p;
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pre;
    logic          fire;

`ifdef STEP_BUTTON_INVERT_EN
    assign run_in  = ~run_btn;
    assign step_in = ~step_btn;
`else
    assign run_in  = run_btn;
    assign step_in = step_btn;
`endif

    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_run_db (
        .clk    (clk),
        .resetn (resetn),
        .btn    (run_in),
        .press  (run_p)
    );

    button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_step_db (
        .clk    (clk),
        .resetn (resetn),
        .btn    (step_in),
        .press  (step_p)
    );

    // Next state and enable request; a run press beats a step press.
    always_comb begin
        state_nxt = state;
        unique case (state)
            HALT: begin
                if (run_p)
                    state_nxt = RUN;
                else if (step_p)
                    state_nxt = STEP;
            end
            RUN: begin
                if (run_p)
                    state_nxt = HALT;
            end
            STEP:    state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
        fire = ((state == RUN) && (pre == PRE_MAX) && !run_p)
            || (state_nxt == STEP);
    end

    // State register; reset lands in RUN.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Prescaler counts only in RUN so each RUN entry starts a full period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            pre <= '0;
        else if (state != RUN)
            pre <= '0;
        else if (pre == PRE_MAX)
            pre <= '0;
        else
            pre <= pre + PW'(1);
    end

    // Registered outputs: enable pulse, run flag and pulse counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ce       <= 1'b0;
            running  <= 1'b1;
            ce_count <= '0;
        end else begin
            ce      <= fire;
            running <= (state_nxt == RUN);
            if (fire)
                ce_count <= ce_count + CE_COUNT_W'(1);
        end
    end

endmodule
